mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the per-core data caches and arbitrates their RAM-side interfaces onto the single shared RAM port.
- Each cache's RAM interface (ram_read/ram_write/ram_atomic/ram_addr/ram_data_w/ram_wait/ram_data_r) connects to one master port of this block.
- Round-robin, burst-locked grant: a granted cache keeps the RAM for the whole 16-word line fill or writeback, and for any atomic sequence.

Parameters:
- NUM_PORTS, 2, number of cache master ports (2..4).
- DATA_W, `DATA_W (32), data word width.
- ADDR_W, `DATA_ADDR_W (32), address width.
- MAX_HOLD, 64, grant-hold limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- m_read  in  NUM_PORTS  per-port read request/strobe.
- m_write  in  NUM_PORTS  per-port write request/strobe.
- m_atomic  in  NUM_PORTS  per-port atomic lock request.
- m_addr  in  NUM_PORTS*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W].
- m_data_w  in  NUM_PORTS*DATA_W  packed write data.
- m_wait  out  NUM_PORTS  per-port stall.
- m_data_r  out  DATA_W  read data, broadcast to all ports.
- grant  out  NUM_PORTS  one-hot current owner; all zero when idle.
- ram_read  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_atomic  out  1  to RAM.
- ram_addr  out  ADDR_W  to RAM.
- ram_data_w  out  DATA_W  to RAM.
- ram_wait  in  1  RAM stall.
- ram_data_r  in  DATA_W  RAM read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Registered state: state (IDLE/GRANT), grant_idx, last_idx, and hold_cnt (timeout build only).
- Reset values, effective after the reset edge:
  - state=IDLE, grant=0, last_idx=NUM_PORTS-1, so port 0 wins first.
  - ram_read=ram_write=ram_atomic=0, ram_addr=0, ram_data_w=0.
  - m_wait = all ones, m_data_r=0.
- Request: req[i] = m_read[i] | m_write[i] | m_atomic[i].
- IDLE:
  - If any req, pick the first requesting port scanning last_idx+1, last_idx+2, ... modulo NUM_PORTS.
  - Next edge: grant_idx=pick, state=GRANT.
  - Latency from request to grant is 1 cycle.
- GRANT, outputs combinational from grant_idx:
  - ram_addr, ram_data_w, ram_atomic forwarded from the granted port.
  - ram_write = m_write[g].
  - ram_read = m_read[g] & ~m_write[g]; write wins if both are asserted.
  - m_wait[g] = ram_wait. m_data_r = ram_data_r.
- Non-granted ports, all states: m_wait=1. In IDLE all RAM strobes are 0, ram_addr=0, ram_data_w=0.
- Release: when req[g]=0 at a posedge, last_idx<=g.
  - If another port is requesting, switch to it directly on the same edge (GRANT->GRANT, no idle bubble), using the round-robin scan from g+1.
  - Otherwise go to IDLE.
- Burst lock: the grant is never revoked while req[g]=1 (except via timeout, see below). The cache holds ram_read/ram_write high across all 16 words.
- Atomic: while m_atomic[g]=1 the grant is never revoked, including by the timeout.
- Reset mid-burst: the grant is dropped at the reset edge and RAM strobes go to 0 the same cycle. No partial-transfer recovery is performed.
- A request deasserted before it is granted is simply not granted; there is no latching.
- grant is always one-hot or zero.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt resets to 0 on every new grant and increments each GRANT cycle, saturating at MAX_HOLD.
  - When hold_cnt==MAX_HOLD, m_atomic[g]=0 and another port is requesting, the grant is revoked at the next edge: last_idx<=g and the round-robin switch is taken.
  - The revoked port sees m_wait=1 and must re-request.
- Undefined: no counter; the grant is held until release.

Test Plan:
- Reset with port0 m_read=1, addr 0x0000_1230 -> grant=0b01 one cycle after reset deasserts; ram_read=1, ram_addr=0x0000_1230, m_wait=2'b10 once ram_wait=0.
- Both ports raise m_read in the same cycle from reset -> port0 granted first. After port0 drops its request, port1 is granted on the same edge with no IDLE cycle. On the next simultaneous contention, port1 is skipped and port0 is granted (round-robin).
- Port1 16-word write burst, addresses 0x2000..0x200F, with port0 requesting mid-burst -> grant stays 0b10 for all 16 words and ram_write is continuous. Port0 is granted the cycle after port1 drops m_write.
- Port0 asserts m_read and m_write together, data 0xDEADBEEF -> ram_write=1, ram_read=0, ram_data_w=0xDEADBEEF.
- rst asserted during a port0 burst at word 7 -> after that edge grant=0, ram_read=0, m_wait=2'b11.
- ARB_TIMEOUT_EN, MAX_HOLD=4, port0 holding m_read, port1 requesting:
  - m_atomic[0]=0 -> grant moves to port1 after 4 hold cycles.
  - m_atomic[0]=1 -> port0 keeps the grant indefinitely.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and RAM-side signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/RAM side.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 32
`endif

interface mem_arbiter_if #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DATA_W    = `DATA_W,
    parameter int unsigned ADDR_W    = `DATA_ADDR_W
);
    logic [NUM_PORTS-1:0]        m_read;
    logic [NUM_PORTS-1:0]        m_write;
    logic [NUM_PORTS-1:0]        m_atomic;
    logic [NUM_PORTS*ADDR_W-1:0] m_addr;
    logic [NUM_PORTS*DATA_W-1:0] m_data_w;
    logic [NUM_PORTS-1:0]        m_wait;
    logic [DATA_W-1:0]           m_data_r;
    logic [NUM_PORTS-1:0]        grant;
    logic                        ram_read;
    logic                        ram_write;
    logic                        ram_atomic;
    logic [ADDR_W-1:0]           ram_addr;
    logic [DATA_W-1:0]           ram_data_w;
    logic                        ram_wait;
    logic [DATA_W-1:0]           ram_data_r;

    modport slave (
        input  m_read, m_write, m_atomic, m_addr, m_data_w, ram_wait, ram_data_r,
        output m_wait, m_data_r, grant, ram_read, ram_write, ram_atomic, ram_addr, ram_data_w
    );

    modport master (
        output m_read, m_write, m_atomic, m_addr, m_data_w, ram_wait, ram_data_r,
        input  m_wait, m_data_r, grant, ram_read, ram_write, ram_atomic, ram_addr, ram_data_w
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin, burst-locked arbiter of per-core cache RAM ports onto one RAM port.
// Define ARB_TIMEOUT_EN to revoke non-atomic grants held for MAX_HOLD cycles under contention.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 32
`endif

module mem_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DATA_W    = `DATA_W,
    parameter int unsigned ADDR_W    = `DATA_ADDR_W,
    parameter int unsigned MAX_HOLD  = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 4 || MAX_HOLD == 0) begin : g_param_check
        $error("mem_arbiter: NUM_PORTS must be 2..4 and MAX_HOLD nonzero");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     grant_idx, grant_idx_n;
    logic [IDX_W-1:0]     last_idx, last_idx_n;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] others;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
`endif

    // First requester strictly after base, wrapping; base itself is scanned last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      k;
        pick  = base;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            k = (32'(base) + i) % NUM_PORTS;
            if (!found && r[k[IDX_W-1:0]]) begin
                pick  = k[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign req    = bus.m_read | bus.m_write | bus.m_atomic;
    assign others = req & ~(NUM_PORTS'(1) << grant_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(NUM_PORTS - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_n;
            grant_idx <= grant_idx_n;
            last_idx  <= last_idx_n;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        grant_idx_n = grant_idx;
        last_idx_n  = last_idx;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_n  = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_idx_n = rr_pick(req, last_idx);
                    state_n     = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_n  = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    last_idx_n = grant_idx;
                    if (|others) begin
                        grant_idx_n = rr_pick(others, grant_idx);
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_n  = '0;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_W'(MAX_HOLD) && !bus.m_atomic[grant_idx] && |others) begin
                    last_idx_n  = grant_idx;
                    grant_idx_n = rr_pick(others, grant_idx);
                    hold_cnt_n  = '0;
                end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.m_wait     = '1;
        bus.m_data_r   = '0;
        bus.grant      = '0;
        bus.ram_read   = 1'b0;
        bus.ram_write  = 1'b0;
        bus.ram_atomic = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_data_w = '0;
        if (state == GRANT) begin
            bus.grant[grant_idx]  = 1'b1;
            bus.m_wait[grant_idx] = bus.ram_wait;
            bus.m_data_r          = bus.ram_data_r;
            bus.ram_write         = bus.m_write[grant_idx];
            bus.ram_read          = bus.m_read[grant_idx] & ~bus.m_write[grant_idx];
            bus.ram_atomic        = bus.m_atomic[grant_idx];
            bus.ram_addr          = bus.m_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
            bus.ram_data_w        = bus.m_data_w[32'(grant_idx) * DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with two cache ports.
// Each scenario queues per-cycle stimulus and expected outputs, then replays and compares.
`timescale 1ns/1ps

module tb_mem_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned MAX_HOLD = 4;
`else
    localparam int unsigned MAX_HOLD = 64;
`endif

    typedef struct packed {
        logic        r;
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [1:0]  at;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rw;
        logic [31:0] rdat;
    } stim_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic        rd;
        logic        wr;
        logic        at;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  wt;
        logic [31:0] mdr;
    } obs_t;

    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    stim_t stim_q[$];
    obs_t  exp_q[$];

    mem_arbiter_if #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32)) bus ();

    mem_arbiter #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic stim_t st(input logic r, input logic [1:0] rd, wr, at,
                                 input logic [31:0] a0, a1, d0, d1,
                                 input logic rw, input logic [31:0] rdat);
        return '{r, rd, wr, at, a0, a1, d0, d1, rw, rdat};
    endfunction

    function automatic obs_t mk(input logic [1:0] g, input logic rd, wr, at,
                                input logic [31:0] addr, wd, input logic [1:0] wt,
                                input logic [31:0] mdr);
        return '{g, rd, wr, at, addr, wd, wt, mdr};
    endfunction

    function automatic obs_t sample();
        return '{bus.grant, bus.ram_read, bus.ram_write, bus.ram_atomic,
                 bus.ram_addr, bus.ram_data_w, bus.m_wait, bus.m_data_r};
    endfunction

    task automatic apply(input stim_t s);
        rst            = s.r;
        bus.m_read     = s.rd;
        bus.m_write    = s.wr;
        bus.m_atomic   = s.at;
        bus.m_addr     = {s.a1, s.a0};
        bus.m_data_w   = {s.d1, s.d0};
        bus.ram_wait   = s.rw;
        bus.ram_data_r = s.rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        int   c = 0;
        stim_q.push_back(st(1, 2'b01, 0, 0, 32'h0000_1230, 0, 0, 0, 0, 32'h11));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(0, 2'b01, 0, 0, 32'h0000_1230, 0, 0, 0, 0, 32'h11));
        exp_q.push_back(mk(2'b01, 1, 0, 0, 32'h0000_1230, 0, 2'b10, 32'h11));
        stim_q.push_back(st(0, 2'b00, 0, 0, 32'h0000_1230, 0, 0, 0, 0, 32'h11));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                $display("FAIL reset cyc%0d got=%h exp=%h", c, got, e);
                errors++;
            end
            c++;
        end
    endtask

    task automatic test_round_robin();
        obs_t got, e;
        int   c = 0;
        logic [31:0] a0 = 32'h100, a1 = 32'h200, rd = 32'hAA;
        stim_q.push_back(st(1, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(0, 2'b11, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b01, 1, 0, 0, a0, 0, 2'b10, rd));
        stim_q.push_back(st(0, 2'b10, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b10, 1, 0, 0, a1, 0, 2'b01, rd));
        stim_q.push_back(st(0, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(0, 2'b11, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b01, 1, 0, 0, a0, 0, 2'b10, rd));
        stim_q.push_back(st(0, 2'b01, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b01, 1, 0, 0, a0, 0, 2'b10, rd));
        stim_q.push_back(st(0, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(0, 2'b11, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b10, 1, 0, 0, a1, 0, 2'b01, rd));
        stim_q.push_back(st(0, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                $display("FAIL round_robin cyc%0d got=%h exp=%h", c, got, e);
                errors++;
            end
            c++;
        end
    endtask

    task automatic test_burst_lock();
        obs_t got, e;
        int   c = 0;
        logic [31:0] a0 = 32'h3100, d0 = 32'h77;
        for (int k = 0; k < 16; k++) begin
            logic rw;
            rw = (k == 5);
            stim_q.push_back(st(0, (k >= 3) ? 2'b01 : 2'b00, 2'b10, 0, a0, 32'h2000 + k,
                                d0, 32'hB000_0000 + k, rw, 32'h5000 + k));
            exp_q.push_back(mk(2'b10, 0, 1, 0, 32'h2000 + k, 32'hB000_0000 + k,
                               {rw, 1'b1}, 32'h5000 + k));
        end
        stim_q.push_back(st(0, 2'b01, 0, 0, a0, 32'h200F, d0, 0, 0, 32'h6000));
        exp_q.push_back(mk(2'b01, 1, 0, 0, a0, d0, 2'b10, 32'h6000));
        stim_q.push_back(st(0, 2'b00, 0, 0, a0, 32'h200F, d0, 0, 0, 32'h6000));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                $display("FAIL burst_lock cyc%0d got=%h exp=%h", c, got, e);
                errors++;
            end
            c++;
        end
    endtask

    task automatic test_write_priority();
        obs_t got, e;
        int   c = 0;
        logic [31:0] a0 = 32'h3000, d0 = 32'hDEAD_BEEF, rd = 32'h1234_5678;
        stim_q.push_back(st(0, 2'b01, 2'b01, 0, a0, 32'h9000, d0, 32'h99, 0, rd));
        exp_q.push_back(mk(2'b01, 0, 1, 0, a0, d0, 2'b10, rd));
        stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, a0, 32'h9000, d0, 32'h99, 0, rd));
        exp_q.push_back(mk(2'b01, 0, 1, 1, a0, d0, 2'b10, rd));
        stim_q.push_back(st(0, 2'b11, 2'b01, 0, a0, 32'h9000, d0, 32'h99, 1, rd));
        exp_q.push_back(mk(2'b01, 0, 1, 0, a0, d0, 2'b11, rd));
        stim_q.push_back(st(0, 2'b00, 2'b00, 0, a0, 32'h9000, d0, 32'h99, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                $display("FAIL write_priority cyc%0d got=%h exp=%h", c, got, e);
                errors++;
            end
            c++;
        end
    endtask

    task automatic test_reset_mid_burst();
        obs_t got, e;
        int   c = 0;
        logic [31:0] rd = 32'h0BAD_F00D;
        for (int k = 0; k < 8; k++) begin
            // port1 pulses a request once mid-burst; it must never be granted later
            stim_q.push_back(st(0, (k == 4) ? 2'b11 : 2'b01, 0, 0, 32'h4000 + k, 32'h4100,
                                0, 0, 0, rd));
            exp_q.push_back(mk(2'b01, 1, 0, 0, 32'h4000 + k, 0, 2'b10, rd));
        end
        stim_q.push_back(st(1, 2'b01, 0, 0, 32'h4008, 32'h4100, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(0, 2'b00, 0, 0, 32'h4008, 32'h4100, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                $display("FAIL reset_mid_burst cyc%0d got=%h exp=%h", c, got, e);
                errors++;
            end
            c++;
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        obs_t got, e;
        int   c = 0;
        logic [31:0] a0 = 32'h5000, a1 = 32'h5100, rd = 32'h77;
        stim_q.push_back(st(1, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(0, 2'b01, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b01, 1, 0, 0, a0, 0, 2'b10, rd));
        for (int k = 0; k < 4; k++) begin
            stim_q.push_back(st(0, 2'b11, 0, 0, a0, a1, 0, 0, 0, rd));
            exp_q.push_back(mk(2'b01, 1, 0, 0, a0, 0, 2'b10, rd));
        end
        stim_q.push_back(st(0, 2'b11, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b10, 1, 0, 0, a1, 0, 2'b01, rd));
        stim_q.push_back(st(0, 2'b01, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b01, 1, 0, 0, a0, 0, 2'b10, rd));
        stim_q.push_back(st(0, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(1, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        stim_q.push_back(st(0, 2'b01, 0, 2'b01, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b01, 1, 0, 1, a0, 0, 2'b10, rd));
        for (int k = 0; k < 10; k++) begin
            stim_q.push_back(st(0, 2'b11, 0, 2'b01, a0, a1, 0, 0, 0, rd));
            exp_q.push_back(mk(2'b01, 1, 0, 1, a0, 0, 2'b10, rd));
        end
        stim_q.push_back(st(0, 2'b11, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b10, 1, 0, 0, a1, 0, 2'b01, rd));
        stim_q.push_back(st(0, 2'b00, 0, 0, a0, a1, 0, 0, 0, rd));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b11, 0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                $display("FAIL timeout cyc%0d got=%h exp=%h", c, got, e);
                errors++;
            end
            c++;
        end
    endtask
`endif

    initial begin
        apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_write_priority();
        test_reset_mid_burst();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
